mem_responder: RTL and testbench

Memory-side responder for the status counter's operand/fetch handshake. Accepts a single-word read or write request from the controller, waits a fixed number of wait-state cycles, then returns a one-cycle ACK with read data. It sits between the controller's FF-phase request and the on-chip data memory. It is the slave end of the REQ/ACK exchange the controller's FF1 state waits on.

---
 rtl/mem_resp_pkg.sv | 16 +
 rtl/mem_resp_array.sv | 29 ++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder REQ/ACK memory slave.
// Optional write protection is enabled with the MEM_RESP_WP_EN macro.
package mem_resp_pkg;

   localparam int CNT_W    = 4;
   localparam int MAX_WAIT = (1 << CNT_W) - 1;
   localparam int DEF_AW   = 8;
   localparam int DEF_DW   = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// DW x 2^AW data storage: synchronous write, synchronous read into a
// resettable output register. Storage itself is never cleared.
module mem_resp_array
   import mem_resp_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  rdata <= '0;
      else if (re)   rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// REQ/ACK memory responder: IDLE -> WAIT (WAIT_CYCLES) -> one-cycle ACK.
// Define MEM_RESP_WP_EN to block writes at addresses >= WP_BASE.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int             AW          = DEF_AW,
   parameter int             DW          = DEF_DW,
   parameter int             WAIT_CYCLES = 2,
   parameter logic [AW-1:0]  WP_BASE     = AW'(8'hF0)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          REQ,
   input  logic          WE,
   input  logic [AW-1:0] ADDR,
   input  logic [DW-1:0] WDATA,
   output logic          ACK,
   output logic [DW-1:0] RDATA,
   output logic          BUSY,
   output logic          WP_ERR
);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
      $error("mem_responder: WAIT_CYCLES must be within 0..15");
   end

   localparam logic [CNT_W-1:0] CNT_LOAD =
      CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             we_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q;
   logic             ack_q;

   logic             enter_ack;
   logic             op_we;
   logic [AW-1:0]    op_addr;
   logic [DW-1:0]    op_wdata;
   logic             wp_block;
   logic             mem_we;
   logic             mem_re;

   // With zero wait states the access happens on the accept edge, so the
   // live bus is used; otherwise the captured copy drives the array.
   always_comb begin
      op_we     = (state == S_IDLE) ? WE    : we_q;
      op_addr   = (state == S_IDLE) ? ADDR  : addr_q;
      op_wdata  = (state == S_IDLE) ? WDATA : wdata_q;
      enter_ack = ((state == S_IDLE) && REQ && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (cnt == '0));
`ifdef MEM_RESP_WP_EN
      wp_block  = op_we && (op_addr >= WP_BASE);
`else
      wp_block  = 1'b0;
`endif
      // reset_n gate drops a write whose commit edge coincides with reset
      mem_we    = enter_ack && op_we && !wp_block && reset_n;
      mem_re    = enter_ack && !op_we;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         ack_q <= enter_ack;
         case (state)
            S_IDLE: begin
               if (REQ) begin
                  we_q    <= WE;
                  addr_q  <= ADDR;
                  wdata_q <= WDATA;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_ACK;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == '0) state <= S_ACK;
               else           cnt   <= cnt - 1'b1;
            end
            S_ACK:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MEM_RESP_WP_EN
   logic wp_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wp_q <= 1'b0;
      else          wp_q <= enter_ack && wp_block;
   end

   assign WP_ERR = wp_q;
`else
   logic unused_wp;
   assign unused_wp = ^{WP_BASE, wp_block};
   assign WP_ERR    = 1'b0;
`endif

   mem_resp_array #(.AW(AW), .DW(DW)) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (mem_we),
      .re      (mem_re),
      .addr    (op_addr),
      .wdata   (op_wdata),
      .rdata   (RDATA)
   );

   assign ACK  = ack_q;
   assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one
// with 0, checked each cycle against a transaction-level model.
module tb_mem_responder;

   logic       clk;
   logic       reset_n;
   logic       req   [2];
   logic       we    [2];
   logic [7:0] addr  [2];
   logic [7:0] wdata [2];
   logic       ack   [2];
   logic [7:0] rdata [2];
   logic       busy  [2];
   logic       wp    [2];

   int vectors = 0;
   int errs    = 0;
   int cyc     = 0;

   mem_responder #(.AW(8), .DW(8), .WAIT_CYCLES(2), .WP_BASE(8'hF0)) u_w2 (
      .clk(clk), .reset_n(reset_n), .REQ(req[0]), .WE(we[0]), .ADDR(addr[0]),
      .WDATA(wdata[0]), .ACK(ack[0]), .RDATA(rdata[0]), .BUSY(busy[0]),
      .WP_ERR(wp[0]));

   mem_responder #(.AW(8), .DW(8), .WAIT_CYCLES(0), .WP_BASE(8'hF0)) u_w0 (
      .clk(clk), .reset_n(reset_n), .REQ(req[1]), .WE(we[1]), .ADDR(addr[1]),
      .WDATA(wdata[1]), .ACK(ack[1]), .RDATA(rdata[1]), .BUSY(busy[1]),
      .WP_ERR(wp[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit         pend    [2];
   int         ack_at  [2];
   bit         m_we    [2];
   logic [7:0] m_addr  [2];
   logic [7:0] m_data  [2];
   logic [7:0] mem_m   [2][256];
   bit         mknown  [2][256];
   logic [7:0] rd_exp  [2];
   bit         rd_known[2];
   bit         wp_flag [2];

   function automatic int waits(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic bit blocked(input bit w, input logic [7:0] a);
`ifdef MEM_RESP_WP_EN
      return w && (a >= 8'hF0);
`else
      return 1'b0 && w && (a == 8'h00);
`endif
   endfunction

   task automatic model_op(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
      if (!w) begin
         rd_exp[i]   <= mem_m[i][a];
         rd_known[i] <= mknown[i][a];
         wp_flag[i]  <= 1'b0;
      end else if (blocked(w, a)) begin
         wp_flag[i]  <= 1'b1;
      end else begin
         mem_m[i][a]  <= d;
         mknown[i][a] <= 1'b1;
         wp_flag[i]   <= 1'b0;
      end
   endtask

   // cyc here is the index of the cycle that this edge ends
   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            pend[i]     <= 1'b0;
            rd_exp[i]   <= 8'h00;
            rd_known[i] <= 1'b1;
            wp_flag[i]  <= 1'b0;
         end else if (pend[i] && cyc == ack_at[i]) begin
            pend[i] <= 1'b0;
         end else if (!pend[i] && req[i]) begin
            pend[i]   <= 1'b1;
            ack_at[i] <= cyc + 1 + waits(i);
            m_we[i]   <= we[i];
            m_addr[i] <= addr[i];
            m_data[i] <= wdata[i];
            if (waits(i) == 0) model_op(i, we[i], addr[i], wdata[i]);
         end else if (pend[i] && cyc + 1 == ack_at[i]) begin
            model_op(i, m_we[i], m_addr[i], m_data[i]);
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         automatic bit e_ack = pend[i] && (cyc == ack_at[i]);
         check($sformatf("ack[%0d]", i), ack[i], e_ack);
         check($sformatf("busy[%0d]", i), busy[i], pend[i]);
         check($sformatf("wp_err[%0d]", i), wp[i], e_ack && wp_flag[i]);
         if (rd_known[i]) check($sformatf("rdata[%0d]", i), rdata[i], rd_exp[i]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic start(input int i, input bit w, input logic [7:0] a,
                        input logic [7:0] d, output int st);
      req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
      st = cyc;
   endtask

   task automatic wait_ack(input int i, input int st, output int lat,
                           output logic [7:0] rd, output logic wpo);
      lat = -1; rd = 8'hxx; wpo = 1'bx;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ack[i]) begin
            lat = cyc - st; rd = rdata[i]; wpo = wp[i];
            req[i] = 1'b0;
            return;
         end
      end
      vectors++; errs++;
      $display("FAIL ack_timeout[%0d]: no ACK within 40 cycles", i);
      req[i] = 1'b0;
   endtask

   task automatic xfer(input int i, input bit w, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output logic wpo);
      int st;
      start(i, w, a, d, st);
      wait_ack(i, st, lat, rd, wpo);
      @(negedge clk);
   endtask

   initial begin
      int lat, st, nack;
      logic [7:0] rd;
      logic wpo;
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      check("rst_ack", ack[0], 1'b0);
      check("rst_busy", busy[0], 1'b0);
      check("rst_rdata", rdata[0], 8'h00);
      reset_n = 1'b1;
      @(negedge clk);

      // write then read, 2 wait states
      xfer(0, 1, 8'h10, 8'h5A, lat, rd, wpo);
      check("w2_wr_lat", lat, 3);
      xfer(0, 0, 8'h10, 8'h00, lat, rd, wpo);
      check("w2_rd_lat", lat, 3);
      check("w2_rd_data", rd, 8'h5A);
      repeat (2) @(negedge clk);
      check("w2_rd_hold", rdata[0], 8'h5A);

      // bus changes during WAIT must not affect the transfer
      xfer(0, 1, 8'h31, 8'h44, lat, rd, wpo);
      start(0, 1, 8'h30, 8'h11, st);
      @(negedge clk);
      addr[0] = 8'h31; wdata[0] = 8'hEE;
      wait_ack(0, st, lat, rd, wpo);
      @(negedge clk);
      xfer(0, 0, 8'h30, 8'h00, lat, rd, wpo);
      check("capt_data30", rd, 8'h11);
      xfer(0, 0, 8'h31, 8'h00, lat, rd, wpo);
      check("capt_data31", rd, 8'h44);

      // zero wait states
      xfer(1, 1, 8'h40, 8'hC3, lat, rd, wpo);
      check("w0_wr_lat", lat, 1);
      xfer(1, 1, 8'h41, 8'h3C, lat, rd, wpo);
      xfer(1, 0, 8'h40, 8'h00, lat, rd, wpo);
      check("w0_rd_lat", lat, 1);
      check("w0_rd_data", rd, 8'hC3);

      // back-to-back reads with REQ held: ACKs two cycles apart
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h40;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("b2b_ack_k%0d", k), ack[1], (k == 1 || k == 3));
         check($sformatf("b2b_busy_k%0d", k), busy[1], (k == 1 || k == 3));
         if (k == 1) begin check("b2b_rd1", rdata[1], 8'hC3); addr[1] = 8'h41; end
         if (k == 3) begin check("b2b_rd2", rdata[1], 8'h3C); req[1] = 1'b0; end
      end

      // reset landing on the ACK-entry edge of a write drops the write
      xfer(0, 1, 8'h20, 8'h33, lat, rd, wpo);
      start(0, 1, 8'h20, 8'h77, st);
      repeat (2) @(negedge clk);
      #4 reset_n = 1'b0;
      @(negedge clk);
      check("rst_edge_ack", ack[0], 1'b0);
      check("rst_edge_busy", busy[0], 1'b0);
      req[0] = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      xfer(0, 0, 8'h20, 8'h00, lat, rd, wpo);
      check("rst_edge_old", rd, 8'h33);

      // reset mid-WAIT clears outputs at once and leaves no pending ACK
      start(0, 0, 8'h10, 8'h00, st);
      @(negedge clk);
      check("midwait_busy_pre", busy[0], 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("midwait_ack", ack[0], 1'b0);
      check("midwait_busy", busy[0], 1'b0);
      check("midwait_rdata", rdata[0], 8'h00);
      req[0] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      nack = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack[0]) nack++;
      end
      check("midwait_no_ack", nack, 0);

      // write protection region
`ifdef MEM_RESP_WP_EN
      xfer(0, 1, 8'hF4, 8'hAA, lat, rd, wpo);
      check("wp_err_f4", wpo, 1'b1);
      check("wp_lat_f4", lat, 3);
      xfer(0, 1, 8'hEF, 8'h5F, lat, rd, wpo);
      check("wp_err_ef", wpo, 1'b0);
      xfer(0, 0, 8'hEF, 8'h00, lat, rd, wpo);
      check("wp_rd_ef", rd, 8'h5F);
`else
      xfer(0, 1, 8'hF4, 8'hAA, lat, rd, wpo);
      check("nowp_err_f4", wpo, 1'b0);
      xfer(0, 0, 8'hF4, 8'h00, lat, rd, wpo);
      check("nowp_rd_f4", rd, 8'hAA);
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
